// File: rtl/step2_backup_seq_pkg.sv
// -----------------------------------------------------------------------------
// pomdp_pkg
// Shared types and width helpers for the PBVI step2 backup stage.
//   state_e    : backup sequencer states (IDLE, SCAN, ACCUM, DONE)
//   dot_width  : width of an unsigned S-term dot product of DATA_W operands
//   idx_width  : counter/index width for a count of n, never below 1 bit
// -----------------------------------------------------------------------------
package pomdp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Full-precision product width plus growth for the S-term sum.
    function automatic int dot_width(input int data_w, input int n_states);
        return 2 * data_w + $clog2(n_states);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step2_backup_seq_if.sv
// -----------------------------------------------------------------------------
// step2_backup_seq_if
// Bundle between step1/step3 and the step2 backup stage.
//   start               : one-cycle request to run a full backup
//   gamma_intermediate  : alpha vectors [a][o][j][s]
//   gamma_reward        : reward vectors [a][s]
//   point_belief        : belief points [b][s]
//   busy                : run in progress
//   done                : one-cycle completion pulse
//   gamma_action_belief : backed-up vectors [a][b][s]
// master drives the request side, slave is the backup stage.
// -----------------------------------------------------------------------------
interface step2_backup_seq_if #(
    parameter int N_STATES  = 2,
    parameter int N_ALPHA   = 16,
    parameter int N_BELIEF  = 16,
    parameter int N_ACTIONS = 3,
    parameter int N_OBS     = 2,
    parameter int DATA_W    = 16
);
    logic start;
    logic busy;
    logic done;
    logic [N_ACTIONS-1:0][N_OBS-1:0][N_ALPHA-1:0][N_STATES-1:0][DATA_W-1:0] gamma_intermediate;
    logic [N_ACTIONS-1:0][N_STATES-1:0][DATA_W-1:0]                         gamma_reward;
    logic [N_BELIEF-1:0][N_STATES-1:0][DATA_W-1:0]                          point_belief;
    logic [N_ACTIONS-1:0][N_BELIEF-1:0][N_STATES-1:0][DATA_W-1:0]           gamma_action_belief;

    modport master (
        output start, gamma_intermediate, gamma_reward, point_belief,
        input  busy, done, gamma_action_belief
    );

    modport slave (
        input  start, gamma_intermediate, gamma_reward, point_belief,
        output busy, done, gamma_action_belief
    );
endinterface

// File: rtl/step2_backup_seq_argmax.sv
// -----------------------------------------------------------------------------
// argmax_tracker
// Running argmax over a serial stream of dot products, one per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   clear_i    : first element of the scan (j==0); loads unconditionally
//   en_i       : a valid dot product is presented this cycle
//   dot_i      : dot product for candidate j_i
//   j_i        : candidate index
//   max_o      : best dot product so far
//   idx_o      : index of the best candidate so far
// Strict greater-than compare, so ties keep the earliest (lowest) index.
// -----------------------------------------------------------------------------
module argmax_tracker
    import pomdp_pkg::*;
#(
    parameter int DOT_W = dot_width(16, 2),
    parameter int IDX_W = idx_width(16)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DOT_W-1:0] dot_i,
    input  logic [IDX_W-1:0] j_i,
    output logic [DOT_W-1:0] max_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [DOT_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (en_i && (clear_i || (dot_i > max_q))) begin
            max_d = dot_i;
            idx_d = j_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max_o = max_q;
    assign idx_o = idx_q;
endmodule

// File: rtl/step2_backup_seq.sv
// -----------------------------------------------------------------------------
// step2_backup_seq
// Time-multiplexed PBVI backup. For each belief b, every (a,o) pair scans its
// alphas one per cycle keeping a running argmax of alpha.b, then one ACCUM
// cycle writes reward[a] + sum_o alpha[a][o][idx] into gamma_action_belief[a][b].
//   clk   : clock
//   rst_n : synchronous active-low reset (aborts a run, clears outputs)
//   bus   : step2_backup_seq_if.slave (start/busy/done + vector buses)
// Optional build macro STEP2_BACKUP_SAT_EN: the ACCUM sum saturates at
// 2^DATA_W-1 instead of wrapping modulo 2^DATA_W.
// Inputs are read combinationally every cycle and must stay stable while busy.
// -----------------------------------------------------------------------------
module step2_backup_seq
    import pomdp_pkg::*;
#(
    parameter int N_STATES  = 2,
    parameter int N_ALPHA   = 16,
    parameter int N_BELIEF  = 16,
    parameter int N_ACTIONS = 3,
    parameter int N_OBS     = 2,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    step2_backup_seq_if.slave bus
);
    localparam int DOT_W = dot_width(DATA_W, N_STATES);
    localparam int IDX_W = idx_width(N_ALPHA);
    localparam int B_W   = idx_width(N_BELIEF);
    // reward + N_OBS alpha terms
    localparam int SUM_W = DATA_W + $clog2(N_OBS + 1);

    state_e           state_q, state_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [IDX_W-1:0] j_q, j_d;

    logic [N_ACTIONS-1:0][N_OBS-1:0][DOT_W-1:0]                 dot;
    logic [N_ACTIONS-1:0][N_OBS-1:0][IDX_W-1:0]                 idx;
    logic [N_ACTIONS-1:0][N_STATES-1:0][DATA_W-1:0]             acc;
    logic [N_ACTIONS-1:0][N_BELIEF-1:0][N_STATES-1:0][DATA_W-1:0] gab_q;
    logic [SUM_W-1:0]                                           wide;

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    b_d     = '0;
                    j_d     = '0;
                end
            end
            SCAN: begin
                if (j_q == IDX_W'(N_ALPHA - 1)) begin
                    state_d = ACCUM;
                    j_d     = '0;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            ACCUM: begin
                j_d = '0;
                if (b_q == B_W'(N_BELIEF - 1)) begin
                    state_d = DONE;
                    b_d     = '0;
                end else begin
                    state_d = SCAN;
                    b_d     = b_q + B_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            b_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            j_q     <= j_d;
        end
    end

    // ---------------- dot products for candidate j, all (a,o) ----------------
    always_comb begin
        dot = '0;
        for (int a = 0; a < N_ACTIONS; a++)
            for (int o = 0; o < N_OBS; o++)
                for (int s = 0; s < N_STATES; s++)
                    dot[a][o] = dot[a][o]
                              + DOT_W'(bus.gamma_intermediate[a][o][j_q][s])
                              * DOT_W'(bus.point_belief[b_q][s]);
    end

    for (genvar a = 0; a < N_ACTIONS; a++) begin : g_act
        for (genvar o = 0; o < N_OBS; o++) begin : g_obs
            argmax_tracker #(
                .DOT_W (DOT_W),
                .IDX_W (IDX_W)
            ) u_trk (
                .clk     (clk),
                .rst_n   (rst_n),
                .clear_i (j_q == '0),
                .en_i    (state_q == SCAN),
                .dot_i   (dot[a][o]),
                .j_i     (j_q),
                .max_o   (),
                .idx_o   (idx[a][o])
            );
        end
    end

    // ---------------- backed-up vector for the current belief ----------------
    always_comb begin
        acc  = '0;
        wide = '0;
        for (int a = 0; a < N_ACTIONS; a++) begin
            for (int s = 0; s < N_STATES; s++) begin
                wide = SUM_W'(bus.gamma_reward[a][s]);
                for (int o = 0; o < N_OBS; o++)
                    wide = wide + SUM_W'(bus.gamma_intermediate[a][o][idx[a][o]][s]);
`ifdef STEP2_BACKUP_SAT_EN
                acc[a][s] = (wide > SUM_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(wide);
`else
                acc[a][s] = DATA_W'(wide);
`endif
            end
        end
    end

    // Only the current belief's slice is written; everything else holds,
    // including results from a previous run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gab_q <= '0;
        end else if (state_q == ACCUM) begin
            for (int a = 0; a < N_ACTIONS; a++)
                gab_q[a][b_q] <= acc[a];
        end
    end

    assign bus.busy                = (state_q == SCAN) || (state_q == ACCUM);
    assign bus.done                = (state_q == DONE);
    assign bus.gamma_action_belief = gab_q;
endmodule

// File: tb/tb_step2_backup_seq.sv
module tb_step2_backup_seq;
    localparam int DW  = 16;
    // default-parameter instance
    localparam int S0 = 2, A0 = 16, B0 = 16, NA0 = 3, NO0 = 2;
    localparam int LAT0 = B0 * (A0 + 1) + 1;
    // small instance for randomized checking
    localparam int S1 = 3, A1 = 5, B1 = 4, NA1 = 2, NO1 = 3;
    localparam int LAT1 = B1 * (A1 + 1) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    step2_backup_seq_if #(.N_STATES(S0), .N_ALPHA(A0), .N_BELIEF(B0),
                          .N_ACTIONS(NA0), .N_OBS(NO0), .DATA_W(DW)) bus0 ();
    step2_backup_seq_if #(.N_STATES(S1), .N_ALPHA(A1), .N_BELIEF(B1),
                          .N_ACTIONS(NA1), .N_OBS(NO1), .DATA_W(DW)) bus1 ();

    step2_backup_seq #(.N_STATES(S0), .N_ALPHA(A0), .N_BELIEF(B0),
                       .N_ACTIONS(NA0), .N_OBS(NO0), .DATA_W(DW))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    step2_backup_seq #(.N_STATES(S1), .N_ALPHA(A1), .N_BELIEF(B1),
                       .N_ACTIONS(NA1), .N_OBS(NO1), .DATA_W(DW))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int done_at = 0;

    // one alpha-placement scenario on the default instance, all within action a
    typedef struct {
        int a;
        int o1, j1, x1, y1;
        int o2, j2, x2, y2;   // o2 < 0: no second alpha
        int bx, by;           // belief used for every b
        int rx, ry;           // reward[a]
        int ex, ey;           // unreduced expected sum for output[a][b]
    } vec_t;
    vec_t vecs[6];

    // random-test model storage
    int al[NA1][NO1][A1][S1];
    int rw[NA1][S1];
    int be[B1][S1];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint fold(input longint v);
`ifdef STEP2_BACKUP_SAT_EN
        return (v > 65535) ? 65535 : v;
`else
        return v % 65536;
`endif
    endfunction

    task automatic apply_vec(input vec_t v);
        bus0.gamma_intermediate = '0;
        bus0.gamma_reward       = '0;
        bus0.point_belief       = '0;
        bus0.gamma_intermediate[v.a][v.o1][v.j1][0] = 16'(v.x1);
        bus0.gamma_intermediate[v.a][v.o1][v.j1][1] = 16'(v.y1);
        if (v.o2 >= 0) begin
            bus0.gamma_intermediate[v.a][v.o2][v.j2][0] = 16'(v.x2);
            bus0.gamma_intermediate[v.a][v.o2][v.j2][1] = 16'(v.y2);
        end
        for (int b = 0; b < B0; b++) begin
            bus0.point_belief[b][0] = 16'(v.bx);
            bus0.point_belief[b][1] = 16'(v.by);
        end
        bus0.gamma_reward[v.a][0] = 16'(v.rx);
        bus0.gamma_reward[v.a][1] = 16'(v.ry);
    endtask

    // expected: action ea gets (ex,ey) after reduction, all others zero
    task automatic check_out0(input string tag, input int ea, input longint ex, input longint ey);
        for (int a = 0; a < NA0; a++)
            for (int b = 0; b < B0; b++) begin
                chk($sformatf("%s_a%0d_b%0d_s0", tag, a, b),
                    bus0.gamma_action_belief[a][b][0], (a == ea) ? fold(ex) : 0);
                chk($sformatf("%s_a%0d_b%0d_s1", tag, a, b),
                    bus0.gamma_action_belief[a][b][1], (a == ea) ? fold(ey) : 0);
            end
    endtask

    // Pulse start; extra start pulses at run cycles x1/x2; optional start in DONE.
    // lat = cycles from the start-sampling edge (counted as 1) to the done cycle.
    task automatic run0(input int x1, input int x2, input bit start_in_done, output int lat);
        int cyc;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        cyc = 1;
        chk("busy_after_start", bus0.busy, 1);
        while (!bus0.done && cyc < 2000) begin
            bus0.start = (cyc == x1) || (cyc == x2);
            tick();
            cyc++;
        end
        bus0.start = 1'b0;
        lat = bus0.done ? cyc : -1;
        if (bus0.done) begin
            done_at = edge_cnt;
            chk("busy_in_done", bus0.busy, 0);
            bus0.start = start_in_done;
            tick();
            bus0.start = 1'b0;
            chk("done_one_cycle", bus0.done, 0);
            chk("busy_after_done", bus0.busy, 0);
            if (start_in_done) begin
                tick();
                chk("start_in_done_ignored", bus0.busy, 0);
            end
        end
    endtask

    task automatic run1(output int lat);
        int cyc;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = 1;
        while (!bus1.done && cyc < 200) begin
            tick();
            cyc++;
        end
        lat = bus1.done ? cyc : -1;
        tick();
    endtask

    initial begin
        int lat;
        int d1;
        int done_seen;
        vec_t v;

        vecs[0] = '{0, 0, 5, 10, 0, -1, 0, 0, 0, 1, 0, 0, 0, 10, 0};
        vecs[1] = '{1, 1, 3, 4, 4, 1, 9, 4, 4, 1, 1, 1, 2, 5, 6};
        vecs[2] = '{1, 1, 3, 4, 4, 1, 9, 8, 0, 1, 1, 1, 2, 5, 6};        // equal dots, distinct vectors
        vecs[3] = '{2, 0, 7, 16, 0, 1, 2, 16, 0, 1, 0, 65520, 0, 65552, 0}; // wrap / saturate
        vecs[4] = '{0, 1, 0, 100, 1, 1, 15, 7, 2, 0, 3, 5, 5, 12, 7};    // last index wins
        vecs[5] = '{2, 0, 15, 1, 0, 1, 0, 0, 9, 2, 0, 3, 0, 4, 9};       // all-zero dots pick j=0

        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus0.gamma_intermediate = '0; bus0.gamma_reward = '0; bus0.point_belief = '0;
        bus1.gamma_intermediate = '0; bus1.gamma_reward = '0; bus1.point_belief = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_busy1", bus1.busy, 0);
        check_out0("rst", 0, 0, 0);

        // table-driven scenarios
        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            run0(-1, -1, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), lat, LAT0);
            check_out0($sformatf("vec%0d", i), vecs[i].a, vecs[i].ex, vecs[i].ey);
        end

        // outputs hold while idle even when inputs move
        bus0.gamma_intermediate = '1;
        bus0.gamma_reward       = '1;
        bus0.point_belief       = '1;
        repeat (5) tick();
        check_out0("hold", vecs[5].a, vecs[5].ex, vecs[5].ey);

        // start re-pulsed mid-run and in the DONE cycle
        apply_vec(vecs[1]);
        run0(5, 200, 1'b1, lat);
        chk("restart_ignored_latency", lat, LAT0);
        check_out0("restart", vecs[1].a, vecs[1].ex, vecs[1].ey);

        // back-to-back: start in the cycle after done
        apply_vec(vecs[0]);
        run0(-1, -1, 1'b0, lat);
        d1 = done_at;
        run0(-1, -1, 1'b0, lat);
        chk("b2b_done_spacing", done_at - d1, LAT0 + 1);
        check_out0("b2b", vecs[0].a, vecs[0].ex, vecs[0].ey);

        // reset mid-run
        apply_vec(vecs[4]);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        done_seen = 0;
        for (int c = 1; c < 100; c++) begin
            tick();
            if (bus0.done) done_seen++;
        end
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", bus0.busy, 0);
        chk("midrst_done", bus0.done, 0);
        check_out0("midrst", 0, 0, 0);
        rst_n = 1'b1;
        repeat (300) begin
            tick();
            if (bus0.done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        run0(-1, -1, 1'b0, lat);
        chk("after_rst_latency", lat, LAT0);
        check_out0("after_rst", vecs[4].a, vecs[4].ex, vecs[4].ey);

        // randomized against a behavioural model, small parameter set
        for (int it = 0; it < 24; it++) begin
            int hi;
            hi = (it % 3 == 0) ? 3 : 65535;
            for (int a = 0; a < NA1; a++) begin
                for (int s = 0; s < S1; s++) begin
                    rw[a][s] = (it % 3 == 2) ? int'($urandom_range(60000, 65535))
                                             : int'($urandom_range(0, hi));
                    bus1.gamma_reward[a][s] = 16'(rw[a][s]);
                end
                for (int o = 0; o < NO1; o++)
                    for (int j = 0; j < A1; j++)
                        for (int s = 0; s < S1; s++) begin
                            al[a][o][j][s] = int'($urandom_range(0, hi));
                            bus1.gamma_intermediate[a][o][j][s] = 16'(al[a][o][j][s]);
                        end
            end
            for (int b = 0; b < B1; b++)
                for (int s = 0; s < S1; s++) begin
                    be[b][s] = int'($urandom_range(0, hi));
                    bus1.point_belief[b][s] = 16'(be[b][s]);
                end

            run1(lat);
            chk($sformatf("rnd%0d_latency", it), lat, LAT1);

            for (int a = 0; a < NA1; a++)
                for (int b = 0; b < B1; b++) begin
                    longint tot[S1];
                    for (int s = 0; s < S1; s++) tot[s] = rw[a][s];
                    for (int o = 0; o < NO1; o++) begin
                        longint bestv;
                        int best;
                        bestv = -1;
                        best  = 0;
                        // best score, earliest index among equals
                        for (int j = 0; j < A1; j++) begin
                            longint d;
                            d = 0;
                            for (int s = 0; s < S1; s++)
                                d += longint'(al[a][o][j][s]) * longint'(be[b][s]);
                            if (d > bestv) begin
                                bestv = d;
                                best  = j;
                            end
                        end
                        for (int s = 0; s < S1; s++) tot[s] += al[a][o][best][s];
                    end
                    for (int s = 0; s < S1; s++)
                        chk($sformatf("rnd%0d_a%0d_b%0d_s%0d", it, a, b, s),
                            bus1.gamma_action_belief[a][b][s], fold(tot[s]));
                end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
